// File: rtl/dev_latch_port_bank_pkg.sv
// Shared types and limits for the I/O-mapped latch port bank.
package dev_latch_port_bank_pkg;

    // Largest bank the mapper select and decode logic are sized for.
    localparam int LATCH_MAX_CHANNELS = 8;

    // Per-channel update behaviour; MODE_RSVD is treated as a plain latch.
    typedef enum logic [1:0] {
        MODE_LATCH  = 2'd0,
        MODE_SETCLR = 2'd1,
        MODE_PULSE  = 2'd2,
        MODE_RSVD   = 2'd3
    } latch_mode_t;

endpackage

// File: rtl/latch_port_ch.sv
// One latch channel: stored value, mode-dependent update and pulse timer.
module latch_port_ch
    import dev_latch_port_bank_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                PULSE_W   = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we_i,
    input  logic [7:0]         wdata_i,
    input  latch_mode_t        mode_i,
    input  logic [PULSE_W-1:0] pulse_len_i,
    output logic [DATA_W-1:0]  value_o,
    output logic               wr_pulse_o
);

    localparam logic [PULSE_W-1:0] CNT_ONE = PULSE_W'(1);

    logic [DATA_W-1:0]  value_q, value_d;
    logic [PULSE_W-1:0] cnt_q, cnt_d;
    logic               wr_pulse_q;

    // Next value and pulse counter from the write strobe, mode and timer.
    always_comb begin
        // NOTE: defaults first so every path assigns value_d/cnt_d and no latch is inferred.
        value_d = value_q;
        cnt_d   = cnt_q;
        if (we_i) begin
            unique case (mode_i)
                MODE_SETCLR: begin
                    // Bit indices beyond the latch width are silently dropped.
                    for (int b = 0; b < DATA_W; b++) begin
                        if (int'(wdata_i[2:0]) == b) begin
                            value_d[b] = wdata_i[7];
                        end
                    end
                    cnt_d = '0;
                end
                MODE_PULSE: begin
                    // A zero length loads a zero counter: the value then holds.
                    value_d = wdata_i[DATA_W-1:0];
                    cnt_d   = pulse_len_i;
                end
                default: begin
                    value_d = wdata_i[DATA_W-1:0];
                    cnt_d   = '0;
                end
            endcase
        end else if (mode_i != MODE_PULSE) begin
            // Leaving pulse mode abandons any pending expiry, value untouched.
            cnt_d = '0;
        end else if (cnt_q == CNT_ONE) begin
            value_d = RESET_VAL;
            cnt_d   = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Channel state registers; reset aborts any pulse immediately.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the latch is a plain flop, not a memory, so it takes the async reset like any state.
        if (reset) begin
            value_q    <= RESET_VAL;
            cnt_q      <= '0;
            wr_pulse_q <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            value_q    <= value_d;
            cnt_q      <= cnt_d;
            wr_pulse_q <= we_i;
        end
    end

    assign value_o    = value_q;
    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: rtl/dev_latch_port_bank.sv
// Bank of I/O-mapped latch channels decoded from Z80 I/O cycles, with a
// mapper-facing value mux and registered CPU readback.
module dev_latch_port_bank
    import dev_latch_port_bank_pkg::*;
#(
    parameter int                CHANNELS  = 3,
    parameter int                DATA_W    = 8,
    parameter int                PULSE_W   = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int               SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [7:0]                        addr,
    input  logic [7:0]                        wdata,
    input  logic                              iorq,
    input  logic                              m1,
    input  logic                              wr,
    input  logic                              rd,
    input  logic                              req,
    input  logic [CHANNELS-1:0]               ch_enable,
    input  logic [CHANNELS-1:0][7:0]          ch_port,
    input  logic [CHANNELS-1:0][7:0]          ch_mask,
    input  logic [CHANNELS-1:0][1:0]          ch_mode,
    input  logic [CHANNELS-1:0][PULSE_W-1:0]  ch_pulse_len,
    input  logic                              sel_valid,
    input  logic [SEL_W-1:0]                  sel_num,
    output logic [DATA_W-1:0]                 data_to_mapper,
    output logic [7:0]                        rdata,
    output logic                              rd_ack,
    output logic [CHANNELS-1:0]               wr_pulse
);

    logic [CHANNELS-1:0]             hit;
    logic [CHANNELS-1:0]             we;
    logic [CHANNELS-1:0][DATA_W-1:0] ch_value;
    logic                            rd_fire;
    logic [7:0]                      rdata_d, rdata_q;
    logic                            rd_ack_q;

    // Address decode; interrupt-acknowledge cycles (iorq with m1) never hit.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i] = ch_enable[i] & ((addr & ch_mask[i]) == ch_port[i]) & iorq & ~m1;
            we[i]  = hit[i] & wr & req;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        latch_port_ch #(
            .DATA_W    (DATA_W),
            .PULSE_W   (PULSE_W),
            .RESET_VAL (RESET_VAL)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .we_i        (we[i]),
            .wdata_i     (wdata),
            .mode_i      (latch_mode_t'(ch_mode[i])),
            .pulse_len_i (ch_pulse_len[i]),
            .value_o     (ch_value[i]),
            .wr_pulse_o  (wr_pulse[i])
        );
    end

    // A read only counts when no write shares the cycle; lowest channel wins.
    always_comb begin
        rd_fire = rd & req & ~wr & (|hit);
        rdata_d = 8'hFF;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                rdata_d[DATA_W-1:0] = ch_value[i];
            end
        end
    end

    // Readback registers: data holds between reads, acknowledge is one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q  <= 8'hFF;
            rd_ack_q <= 1'b0;
        end else begin
            rd_ack_q <= rd_fire;
            if (rd_fire) begin
                rdata_q <= rdata_d;
            end
        end
    end

    // Mapper view of the selected channel; out-of-range or unselected reads all ones.
    always_comb begin
        data_to_mapper = '1;
        if (sel_valid) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(sel_num) == i) begin
                    data_to_mapper = ch_value[i];
                end
            end
        end
    end

    assign rdata  = rdata_q;
    assign rd_ack = rd_ack_q;

endmodule
